bpdir_update_queue: RTL and testbench
=====================================

# bpdir_update_queue

Write-side companion to the gshare direction predictor. It accepts resolved branch-direction updates (PHT index plus new 2-bit counter state) from the Memory stage and buffers them in a small FIFO. It drains them into a single-ported pattern history table only on cycles when the Fetch-stage read does not need the port. A youngest-match forwarding path hides pending writes from the Fetch read, so predictions never see stale counters.

## Interface
Parameters:
- `k`, 10: PHT index width; the table has 2**k entries.
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `DROPW`, 8: width of the saturating dropped-update counter.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `PushValidM`  input  1  update offered; the M stage drives it as `BranchM & ~StallM & ~FlushM`.
- `PushIndexM`  input  k  PHT index of the update.
- `PushDataM`  input  2  new saturating-counter state.
- `ReadReqF`  input  1  Fetch needs the PHT port this cycle (driven as `~StallF`).
- `ReadIndexF`  input  k  Fetch lookup index.
- `PHTWe`  output  1  PHT write enable.
- `PHTWa`  output  k  PHT write address.
- `PHTWd`  output  2  PHT write data.
- `FwdHitF`  output  1  `ReadIndexF` matches a queued entry.
- `FwdDataF`  output  2  counter state of the youngest matching queued entry.
- `Full`  output  1  count equals `DEPTH`.
- `Empty`  output  1  count equals 0.
- `DropCount`  output  DROPW  number of updates dropped; saturates at all-ones.

## Operation
- Storage:
  - Circular buffer of `DEPTH` entries, each {valid, index[k-1:0], data[1:0]}.
  - Head and tail pointers, each log2(DEPTH) bits, wrap modulo `DEPTH`.
  - Count register, log2(DEPTH)+1 bits.
- Drain (combinational):
  - `PHTWe = ~Empty & ~ReadReqF`; a Fetch read always has priority.
  - `PHTWa` and `PHTWd` present the head entry whenever the queue is not empty.
  - When `Empty`, `PHTWa` and `PHTWd` are 0.
  - A pop happens on any cycle where `PHTWe` is 1: head advances and that entry's valid bit clears.
- Push:
  - Accepted when `PushValidM & (~Full | pop)`: the entry is written at tail and tail advances.
  - Full with push and pop in the same cycle: both occur and count is unchanged.
  - Full with push and no pop: the push is dropped, the queue is unchanged, and `DropCount` increments unless already saturated.
- Count update: +1 on accept without pop, -1 on pop without accept, otherwise unchanged.
- Forwarding (combinational):
  - Compare `ReadIndexF` against every valid stored entry.
  - `FwdHitF` = any match.
  - `FwdDataF` = data of the matching entry closest to tail (youngest); 0 when no match.
  - An update arriving in the same cycle is not forwarded; it becomes visible the following cycle.
- The consumer muxes `FwdDataF` over the PHT read data when `FwdHitF` is 1. Because the PHT read is synchronous, the consumer registers `FwdHitF` and `FwdDataF` alongside the read.
- Duplicate indices in the queue are legal. They drain in order, so the youngest value lands last.

## Timing
- Reset (asynchronous, `reset`=0), and the state in which the block leaves reset:
  - Pointers, count, valid bits and `DropCount` are 0; entry data is 0.
  - Outputs: `PHTWe`=0, `PHTWa`=0, `PHTWd`=0, `FwdHitF`=0, `FwdDataF`=0, `Full`=0, `Empty`=1, `DropCount`=0.
- Reset asserted mid-operation discards all queued updates; no partial write is emitted after deassertion.
- Push-to-write latency: minimum 1 cycle. An update pushed in cycle N into an empty queue appears on `PHTWe`/`PHTWa`/`PHTWd` in cycle N+1 if `ReadReqF`=0.
- Push-to-forward latency: 1 cycle.
- Starvation: with `ReadReqF` held at 1 the queue never drains. Further pushes fill it and are then dropped. The pipeline is never stalled by this block.
- `Full` and `Empty` are registered-state derived; they are not affected by same-cycle push or pop inputs.

## Test plan
- Single update, `ReadReqF`=0:
  - Stimulus: push {idx=0x2A, data=3} in cycle 0.
  - Response: cycle 1 shows `PHTWe`=1, `PHTWa`=0x2A, `PHTWd`=3; cycle 2 shows `Empty`=1.
- Read priority:
  - Stimulus: `ReadReqF`=1 for 5 cycles with 2 pushes.
  - Response: `PHTWe`=0 throughout and count=2; after `ReadReqF` drops, the two writes occur in consecutive cycles in push order.
- Overflow, `DEPTH`=4, `ReadReqF`=1:
  - Stimulus: 6 pushes.
  - Response: `Full`=1, `DropCount`=2, and the queue holds the first 4 updates.
  - Follow-on: push and pop in the same cycle while full leaves count=4 with `DropCount` unchanged.
- Forwarding youngest match:
  - Stimulus: push {0x10,1} then {0x10,2}, with `ReadIndexF`=0x10.
  - Response: after the first push, `FwdHitF`=1 and `FwdDataF`=1; after the second, `FwdDataF`=2.
  - Response: with `ReadIndexF`=0x11, `FwdHitF`=0.
- Pointer wrap:
  - Stimulus: 10 push/drain cycles with `ReadReqF`=0.
  - Response: every write matches its push order and data, including across the tail and head wrap.
- Mid-operation reset:
  - Stimulus: assert `reset`=0 with 3 entries queued, then release.
  - Response: `Empty`=1, `PHTWe`=0, `DropCount`=0, and no stale writes appear afterward.

Source files
------------

// File: rtl/bpdir_update_queue.sv
// Update queue between the M-stage branch resolver and the gshare PHT.
// Buffers counter writes and drains them only when Fetch leaves the port idle.
module bpdir_update_queue #(
    parameter int k     = 10,
    parameter int DEPTH = 4,
    parameter int DROPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PushValidM,
    input  logic [k-1:0]     PushIndexM,
    input  logic [1:0]       PushDataM,
    input  logic             ReadReqF,
    input  logic [k-1:0]     ReadIndexF,
    output logic             PHTWe,
    output logic [k-1:0]     PHTWa,
    output logic [1:0]       PHTWd,
    output logic             FwdHitF,
    output logic [1:0]       FwdDataF,
    output logic             Full,
    output logic             Empty,
    output logic [DROPW-1:0] DropCount
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DepthC = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] validQ;
    logic [k-1:0]     indexQ [DEPTH];
    logic [1:0]       dataQ  [DEPTH];
    logic [PW-1:0]    headPtr;
    logic [PW-1:0]    tailPtr;
    logic [PW:0]      countQ;
    logic             pop;
    logic             accept;
    logic [PW-1:0]    slot;

    assign Full   = (countQ == DepthC);
    assign Empty  = (countQ == '0);
    assign pop    = ~Empty & ~ReadReqF;
    assign accept = PushValidM & (~Full | pop);

    assign PHTWe = pop;
    assign PHTWa = Empty ? '0 : indexQ[headPtr];
    assign PHTWd = Empty ? '0 : dataQ[headPtr];

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        FwdHitF  = 1'b0;
        FwdDataF = 2'b00;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = headPtr + PW'(i);
            if (validQ[slot] && (indexQ[slot] == ReadIndexF)) begin
                FwdHitF  = 1'b1;
                FwdDataF = dataQ[slot];
            end
        end
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ  <= '0;
            headPtr <= '0;
            tailPtr <= '0;
            countQ  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                indexQ[i] <= '0;
                dataQ[i]  <= '0;
            end
        end else begin
            if (pop) begin
                validQ[headPtr] <= 1'b0;
                headPtr         <= headPtr + 1'b1;
            end
            // When full, tail equals head; the new entry's valid bit wins.
            if (accept) begin
                validQ[tailPtr] <= 1'b1;
                indexQ[tailPtr] <= PushIndexM;
                dataQ[tailPtr]  <= PushDataM;
                tailPtr         <= tailPtr + 1'b1;
            end
            if (accept && !pop) begin
                countQ <= countQ + 1'b1;
            end else if (pop && !accept) begin
                countQ <= countQ - 1'b1;
            end
        end
    end

    // Saturating count of pushes lost to a full, undrained queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            DropCount <= '0;
        end else if (PushValidM && Full && !pop && (DropCount != '1)) begin
            DropCount <= DropCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_bpdir_update_queue.sv
// Directed bench for bpdir_update_queue: cycle table plus wrap/reset sequences.
// Each row gives the inputs of one cycle and the outputs expected during it.
module tb_bpdir_update_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       PushValidM;
    logic [9:0] PushIndexM;
    logic [1:0] PushDataM;
    logic       ReadReqF;
    logic [9:0] ReadIndexF;
    logic       PHTWe;
    logic [9:0] PHTWa;
    logic [1:0] PHTWd;
    logic       FwdHitF;
    logic [1:0] FwdDataF;
    logic       Full;
    logic       Empty;
    logic [7:0] DropCount;

    int nCmp = 0;
    int nBad = 0;

    bpdir_update_queue #(.k(10), .DEPTH(4), .DROPW(8)) dut (
        .clk(clk), .reset(reset),
        .PushValidM(PushValidM), .PushIndexM(PushIndexM),
        .PushDataM(PushDataM), .ReadReqF(ReadReqF),
        .ReadIndexF(ReadIndexF), .PHTWe(PHTWe), .PHTWa(PHTWa),
        .PHTWd(PHTWd), .FwdHitF(FwdHitF), .FwdDataF(FwdDataF),
        .Full(Full), .Empty(Empty), .DropCount(DropCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pv;
        logic [9:0] pIdx;
        logic [1:0] pD;
        logic       rr;
        logic [9:0] rIdx;
        logic       we;
        logic [9:0] wa;
        logic [1:0] wd;
        logic       hit;
        logic [1:0] fd;
        logic       full;
        logic       empty;
        logic [7:0] drop;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic pv, input logic [9:0] pIdx,
                       input logic [1:0] pD, input logic rr,
                       input logic [9:0] rIdx, input logic we,
                       input logic [9:0] wa, input logic [1:0] wd,
                       input logic hit, input logic [1:0] fd,
                       input logic full, input logic empty,
                       input logic [7:0] drop);
        vec_t v;
        v.pv = pv; v.pIdx = pIdx; v.pD = pD; v.rr = rr; v.rIdx = rIdx;
        v.we = we; v.wa = wa; v.wd = wd; v.hit = hit; v.fd = fd;
        v.full = full; v.empty = empty; v.drop = drop;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [9:0] pIdx,
                         input logic [1:0] pD, input logic rr,
                         input logic [9:0] rIdx);
        PushValidM = pv;
        PushIndexM = pIdx;
        PushDataM  = pD;
        ReadReqF   = rr;
        ReadIndexF = rIdx;
    endtask

    initial begin
        //   pv  pIdx    pD rr rIdx  | we wa     wd hit fd full emp drop
        // single update
        add(1, 10'h2A, 3, 0, 10'h2A, 0, 10'h00, 0, 0, 0, 0, 1, 0);
        add(0, 10'h00, 0, 0, 10'h2A, 1, 10'h2A, 3, 1, 3, 0, 0, 0);
        add(0, 10'h00, 0, 0, 10'h2A, 0, 10'h00, 0, 0, 0, 0, 1, 0);
        // read priority
        add(1, 10'h05, 1, 1, 10'h00, 0, 10'h00, 0, 0, 0, 0, 1, 0);
        add(1, 10'h06, 2, 1, 10'h05, 0, 10'h05, 1, 1, 1, 0, 0, 0);
        add(0, 10'h00, 0, 1, 10'h06, 0, 10'h05, 1, 1, 2, 0, 0, 0);
        add(0, 10'h00, 0, 1, 10'h00, 0, 10'h05, 1, 0, 0, 0, 0, 0);
        add(0, 10'h00, 0, 1, 10'h00, 0, 10'h05, 1, 0, 0, 0, 0, 0);
        add(0, 10'h00, 0, 0, 10'h00, 1, 10'h05, 1, 0, 0, 0, 0, 0);
        add(0, 10'h00, 0, 0, 10'h00, 1, 10'h06, 2, 0, 0, 0, 0, 0);
        add(0, 10'h00, 0, 0, 10'h00, 0, 10'h00, 0, 0, 0, 0, 1, 0);
        // overflow with reads holding the port
        add(1, 10'h11, 0, 1, 10'h3FF, 0, 10'h00, 0, 0, 0, 0, 1, 0);
        add(1, 10'h12, 1, 1, 10'h3FF, 0, 10'h11, 0, 0, 0, 0, 0, 0);
        add(1, 10'h13, 2, 1, 10'h3FF, 0, 10'h11, 0, 0, 0, 0, 0, 0);
        add(1, 10'h14, 3, 1, 10'h3FF, 0, 10'h11, 0, 0, 0, 0, 0, 0);
        add(1, 10'h15, 0, 1, 10'h3FF, 0, 10'h11, 0, 0, 0, 1, 0, 0);
        add(1, 10'h16, 1, 1, 10'h3FF, 0, 10'h11, 0, 0, 0, 1, 0, 1);
        add(0, 10'h00, 0, 1, 10'h14, 0, 10'h11, 0, 1, 3, 1, 0, 2);
        add(0, 10'h00, 0, 1, 10'h15, 0, 10'h11, 0, 0, 0, 1, 0, 2);
        // push + pop while full
        add(1, 10'h17, 2, 0, 10'h00, 1, 10'h11, 0, 0, 0, 1, 0, 2);
        add(0, 10'h00, 0, 1, 10'h17, 0, 10'h12, 1, 1, 2, 1, 0, 2);
        add(0, 10'h00, 0, 0, 10'h00, 1, 10'h12, 1, 0, 0, 1, 0, 2);
        add(0, 10'h00, 0, 0, 10'h00, 1, 10'h13, 2, 0, 0, 0, 0, 2);
        add(0, 10'h00, 0, 0, 10'h00, 1, 10'h14, 3, 0, 0, 0, 0, 2);
        add(0, 10'h00, 0, 0, 10'h00, 1, 10'h17, 2, 0, 0, 0, 0, 2);
        add(0, 10'h00, 0, 0, 10'h00, 0, 10'h00, 0, 0, 0, 0, 1, 2);
        // youngest-match forwarding
        add(1, 10'h10, 1, 1, 10'h10, 0, 10'h00, 0, 0, 0, 0, 1, 2);
        add(1, 10'h10, 2, 1, 10'h10, 0, 10'h10, 1, 1, 1, 0, 0, 2);
        add(0, 10'h00, 0, 1, 10'h10, 0, 10'h10, 1, 1, 2, 0, 0, 2);
        add(0, 10'h00, 0, 1, 10'h11, 0, 10'h10, 1, 0, 0, 0, 0, 2);
        add(0, 10'h00, 0, 0, 10'h10, 1, 10'h10, 1, 1, 2, 0, 0, 2);
        add(0, 10'h00, 0, 0, 10'h10, 1, 10'h10, 2, 1, 2, 0, 0, 2);
        add(0, 10'h00, 0, 0, 10'h10, 0, 10'h00, 0, 0, 0, 0, 1, 2);

        // reset state
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        #12;
        chk("rst_we", -1, 32'(PHTWe), 0);
        chk("rst_wa", -1, 32'(PHTWa), 0);
        chk("rst_wd", -1, 32'(PHTWd), 0);
        chk("rst_hit", -1, 32'(FwdHitF), 0);
        chk("rst_fd", -1, 32'(FwdDataF), 0);
        chk("rst_full", -1, 32'(Full), 0);
        chk("rst_empty", -1, 32'(Empty), 1);
        chk("rst_drop", -1, 32'(DropCount), 0);
        @(negedge clk);
        reset = 1'b1;

        // table
        for (int r = 0; r < vq.size(); r++) begin
            @(negedge clk);
            drive(vq[r].pv, vq[r].pIdx, vq[r].pD, vq[r].rr, vq[r].rIdx);
            #1;
            chk("we", r, 32'(PHTWe), 32'(vq[r].we));
            chk("wa", r, 32'(PHTWa), 32'(vq[r].wa));
            chk("wd", r, 32'(PHTWd), 32'(vq[r].wd));
            chk("hit", r, 32'(FwdHitF), 32'(vq[r].hit));
            chk("fd", r, 32'(FwdDataF), 32'(vq[r].fd));
            chk("full", r, 32'(Full), 32'(vq[r].full));
            chk("empty", r, 32'(Empty), 32'(vq[r].empty));
            chk("drop", r, 32'(DropCount), 32'(vq[r].drop));
        end

        // pointer wrap: push every cycle, drain every cycle
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i < 10) drive(1, 10'(10'h100 + i), 2'(i % 4), 0, 0);
            else        drive(0, 0, 0, 0, 0);
            #1;
            if (i > 0) begin
                chk("wrap_we", i, 32'(PHTWe), 1);
                chk("wrap_wa", i, 32'(PHTWa), 32'(10'h100 + i - 1));
                chk("wrap_wd", i, 32'(PHTWd), 32'((i - 1) % 4));
            end else begin
                chk("wrap_we", i, 32'(PHTWe), 0);
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("wrap_empty", 0, 32'(Empty), 1);
        chk("wrap_drop", 0, 32'(DropCount), 2);

        // mid-operation reset with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 10'(10'h200 + i), 2'(i + 1), 1, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 10'h201);
        #1;
        chk("pre_rst_hit", 0, 32'(FwdHitF), 1);
        chk("pre_rst_wa", 0, 32'(PHTWa), 32'(10'h200));
        drive(0, 0, 0, 0, 10'h201);
        reset = 1'b0;
        #1;
        chk("mrst_empty", 0, 32'(Empty), 1);
        chk("mrst_we", 0, 32'(PHTWe), 0);
        chk("mrst_drop", 0, 32'(DropCount), 0);
        chk("mrst_hit", 0, 32'(FwdHitF), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_we", i, 32'(PHTWe), 0);
            chk("post_rst_empty", i, 32'(Empty), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
